// File: rtl/lamp_frame_arbiter_if.sv
// lamp_frame_arbiter_if: requester handshakes and serial-chain outputs of the lamp frame arbiter.
interface lamp_frame_arbiter_if #(
    parameter int WIDTH = 40
);
    logic             req_a;
    logic [WIDTH-1:0] data_a;
    logic             ack_a;
    logic             req_b;
    logic [WIDTH-1:0] data_b;
    logic             ack_b;
    logic             sdata;
    logic             shift_pulse;
    logic             latch_clk;
    logic             busy;
    logic             done;
    logic             grant_src;

    modport master (
        output req_a, data_a, req_b, data_b,
        input  ack_a, ack_b, sdata, shift_pulse, latch_clk, busy, done, grant_src
    );

    modport slave (
        input  req_a, data_a, req_b, data_b,
        output ack_a, ack_b, sdata, shift_pulse, latch_clk, busy, done, grant_src
    );
endinterface

// File: rtl/lamp_frame_arbiter.sv
// lamp_frame_arbiter: round-robin arbiter that shifts a captured frame LSB-first onto the lamp chain
// and latches it, skipping frames identical to the one already latched.
module lamp_frame_arbiter #(
    parameter int WIDTH   = 40,
    parameter int CLK_DIV = 20
) (
    input logic                 sys_clk,
    input logic                 rst,
    lamp_frame_arbiter_if.slave bus
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SETUP = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;
    localparam logic [1:0] LATCH = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] frame_q, frame_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic             last_valid_q, last_valid_d;
    logic             rr_q, rr_d;
    logic             ack_a_q, ack_a_d;
    logic             ack_b_q, ack_b_d;
    logic             sdata_q, sdata_d;
    logic             shift_q, shift_d;
    logic             latch_q, latch_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             grant_q, grant_d;

    logic             elig_a, elig_b, pick_b, dup, phase_end;
    logic [WIDTH-1:0] win_data;
    logic [IW-1:0]    idx_nx;

    // A requester whose ack is showing this cycle has already been served.
    assign elig_a    = bus.req_a & ~ack_a_q;
    assign elig_b    = bus.req_b & ~ack_b_q;
    assign pick_b    = elig_b & (~elig_a | ~rr_q);
    assign win_data  = pick_b ? bus.data_b : bus.data_a;
    assign dup       = last_valid_q & (win_data == shadow_q);
    assign phase_end = cnt_q == CNT_LAST;
    assign idx_nx    = idx_q + IW'(1);
    assign cnt_d     = (state_q == IDLE || phase_end) ? '0 : cnt_q + CW'(1);

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        frame_d      = frame_q;
        shadow_d     = shadow_q;
        last_valid_d = last_valid_q;
        rr_d         = rr_q;
        ack_a_d      = 1'b0;
        ack_b_d      = 1'b0;
        sdata_d      = sdata_q;
        shift_d      = shift_q;
        latch_d      = latch_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        grant_d      = grant_q;
        case (state_q)
            IDLE: if (elig_a | elig_b) begin
                ack_a_d = ~pick_b;
                ack_b_d = pick_b;
                grant_d = pick_b;
                rr_d    = pick_b;
                frame_d = win_data;
                if (!dup) begin
                    state_d = SETUP;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    sdata_d = win_data[0];
                end
            end
            SETUP: if (phase_end) begin
                state_d = SHIFT;
                shift_d = 1'b1;
            end
            SHIFT: if (phase_end) begin
                shift_d = 1'b0;
                if (idx_q != IDX_LAST) begin
                    state_d = SETUP;
                    idx_d   = idx_nx;
                    sdata_d = frame_q[idx_nx];
                end else begin
                    state_d = LATCH;
                    latch_d = 1'b1;
                    sdata_d = 1'b0;
                end
            end
            default: if (phase_end) begin
                state_d      = IDLE;
                latch_d      = 1'b0;
                busy_d       = 1'b0;
                done_d       = 1'b1;
                shadow_d     = frame_q;
                last_valid_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            frame_q      <= '0;
            shadow_q     <= '0;
            last_valid_q <= 1'b0;
            rr_q         <= 1'b1;
            ack_a_q      <= 1'b0;
            ack_b_q      <= 1'b0;
            sdata_q      <= 1'b0;
            shift_q      <= 1'b0;
            latch_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            grant_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            frame_q      <= frame_d;
            shadow_q     <= shadow_d;
            last_valid_q <= last_valid_d;
            rr_q         <= rr_d;
            ack_a_q      <= ack_a_d;
            ack_b_q      <= ack_b_d;
            sdata_q      <= sdata_d;
            shift_q      <= shift_d;
            latch_q      <= latch_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            grant_q      <= grant_d;
        end
    end

    assign bus.ack_a       = ack_a_q;
    assign bus.ack_b       = ack_b_q;
    assign bus.sdata       = sdata_q;
    assign bus.shift_pulse = shift_q;
    assign bus.latch_clk   = latch_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.grant_src   = grant_q;
endmodule
